// File: rtl/vote_pkg.sv
// Shared types, constants and helpers for the vote tally block and its sub-modules.
package vote_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LED_ON  = 8'hFF;
    localparam logic [7:0] LED_OFF = 8'h00;

    // Widest candidate vector accepted by onehot_valid; callers zero-extend.
    localparam int ONEHOT_MAX_W = 16;

    function automatic logic onehot_valid(input logic [ONEHOT_MAX_W-1:0] vec);
        return ($countones(vec) == 1);
    endfunction

    // Running total must hold NUM_CAND saturated counters without wrapping.
    function automatic int total_width(input int num_cand, input int cnt_w);
        return cnt_w + $clog2(num_cand);
    endfunction

endpackage

// File: rtl/vote_max_finder.sv
// Combinational argmax over packed counters: lowest index wins, tie flags a shared maximum.
module vote_max_finder
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    localparam int IDX_W   = $clog2(NUM_CAND)
) (
    input  logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [IDX_W-1:0]          max_idx,
    output logic                      tie
);

    logic [CNT_W-1:0] max_val;

    always_comb begin
        max_val = counts[0 +: CNT_W];
        max_idx = '0;
        tie     = 1'b0;
        // Strict '>' keeps the lowest index on equality; a new leader clears any earlier tie.
        for (int i = 1; i < NUM_CAND; i++) begin
            if (counts[i*CNT_W +: CNT_W] > max_val) begin
                max_val = counts[i*CNT_W +: CNT_W];
                max_idx = IDX_W'(i);
                tie     = 1'b0;
            end else if (counts[i*CNT_W +: CNT_W] == max_val) begin
                tie = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Per-candidate vote counter with saturation, invalid-vote flag, LED acknowledge lockout
// and registered winner/tie reporting in result mode.
module vote_tally
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int LED_HOLD = 4,
    localparam int IDX_W   = $clog2(NUM_CAND),
    localparam int TOT_W   = total_width(NUM_CAND, CNT_W)
) (
    input  logic                      clk,
    input  logic                      reset_all,
    input  logic                      mode,
    input  logic                      vote_logged,
    input  logic [NUM_CAND-1:0]       candidate,
    output logic [7:0]                led,
    output logic [NUM_CAND*CNT_W-1:0] vote_count,
    output logic [TOT_W-1:0]          total_votes,
    output logic                      invalid_vote,
    output logic                      busy,
    output logic [IDX_W-1:0]          winner_idx,
    output logic                      winner_valid,
    output logic                      tie,
    output state_t                    state_dbg
);

    localparam int HOLD_W                = $clog2(LED_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                    state_q, state_d;
    logic [HOLD_W-1:0]         hold_q, hold_d;
    logic                      vl_q, vl_d;
    logic [NUM_CAND*CNT_W-1:0] cnt_q, cnt_d;
    logic [TOT_W-1:0]          total_q, total_d;
    logic                      invalid_q, invalid_d;
    logic [IDX_W-1:0]          win_idx_q, win_idx_d;
    logic                      win_valid_q, win_valid_d;
    logic                      tie_q, tie_d;

    logic                      strobe;
    logic                      cand_ok;
    logic [IDX_W-1:0]          max_idx_c;
    logic                      tie_c;

    assign strobe  = vote_logged & ~vl_q;
    assign cand_ok = onehot_valid(ONEHOT_MAX_W'(candidate));

    vote_max_finder #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_max (
        .counts  (cnt_q),
        .max_idx (max_idx_c),
        .tie     (tie_c)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        invalid_d = 1'b0;
        vl_d      = vote_logged;

        case (state_q)
            IDLE: begin
                if (!mode && strobe) begin
                    if (cand_ok) begin
                        state_d = HOLD;
                        hold_d  = HOLD_W'(LED_HOLD);
                        // A saturated counter still acknowledges, but the total must not drift.
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (candidate[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                                total_d                 = total_q + TOT_W'(1);
                            end
                        end
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_W'(1)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_valid_d = mode && (total_q != '0);
        tie_d       = mode & tie_c;
        win_idx_d   = mode ? max_idx_c : win_idx_q;
    end

    // vl_q resets high so a strobe already asserted at reset release is not counted.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            vl_q        <= 1'b1;
            cnt_q       <= '0;
            total_q     <= '0;
            invalid_q   <= 1'b0;
            win_idx_q   <= '0;
            win_valid_q <= 1'b0;
            tie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            vl_q        <= vl_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            invalid_q   <= invalid_d;
            win_idx_q   <= win_idx_d;
            win_valid_q <= win_valid_d;
            tie_q       <= tie_d;
        end
    end

    assign led          = (state_q == HOLD) ? LED_ON : LED_OFF;
    assign busy         = (state_q == HOLD);
    assign vote_count   = cnt_q;
    assign total_votes  = total_q;
    assign invalid_vote = invalid_q;
    assign winner_idx   = win_idx_q;
    assign winner_valid = win_valid_q;
    assign tie          = tie_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: scoreboard of vote responses plus directed checks.
module tb_vote_tally;
    import vote_pkg::*;

    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int LH  = 4;
    localparam int IW  = $clog2(NC);
    localparam int TW  = CW + $clog2(NC);
    localparam int SBW = 1 + NC*CW + TW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_all;
    logic mode;
    logic vote_logged;
    logic [NC-1:0] candidate;

    logic [7:0]       led;
    logic [NC*CW-1:0] vote_count;
    logic [TW-1:0]    total_votes;
    logic             invalid_vote;
    logic             busy;
    logic [IW-1:0]    winner_idx;
    logic             winner_valid;
    logic             tie;
    state_t           state_dbg;

    always #5 clk = ~clk;

    vote_tally #(
        .NUM_CAND (NC),
        .CNT_W    (CW),
        .LED_HOLD (LH)
    ) dut (
        .clk          (clk),
        .reset_all    (reset_all),
        .mode         (mode),
        .vote_logged  (vote_logged),
        .candidate    (candidate),
        .led          (led),
        .vote_count   (vote_count),
        .total_votes  (total_votes),
        .invalid_vote (invalid_vote),
        .busy         (busy),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid),
        .tie          (tie),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [SBW-1:0] exp_q[$];
    logic [CW-1:0]  m_cnt[NC];
    int             m_total;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SBW-1:0] model_pack(input logic kind);
        logic [NC*CW-1:0] p;
        for (int i = 0; i < NC; i++) p[i*CW +: CW] = m_cnt[i];
        return {kind, p, TW'(m_total)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_cnt[i] = '0;
        m_total = 0;
    endtask

    // Model of one strobe issued while idle: push the response the DUT must produce.
    task automatic model_vote(input logic [NC-1:0] c);
        int hits;
        hits = $countones(c);
        if (!mode) begin
            if (hits == 1) begin
                for (int k = 0; k < NC; k++) begin
                    if (c[k] && m_cnt[k] != 8'hFF) begin
                        m_cnt[k] = m_cnt[k] + 8'd1;
                        m_total  = m_total + 1;
                    end
                end
                exp_q.push_back(model_pack(1'b1));
            end else begin
                exp_q.push_back(model_pack(1'b0));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(input logic [NC-1:0] c, input int gap);
        vote_logged = 1'b0;
        step();
        model_vote(c);
        candidate   = c;
        vote_logged = 1'b1;
        step();
        vote_logged = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        reset_all = 1'b1;
        step();
        step();
        reset_all = 1'b0;
        model_clear();
    endtask

    // ---------------- response monitor ----------------
    logic busy_prev = 1'b0;
    int   busy_run  = 0;
    int   led_run   = 0;

    always @(negedge clk) begin
        if (reset_all) begin
            busy_prev = 1'b0;
            busy_run  = 0;
            led_run   = 0;
        end else begin
            if ((busy && !busy_prev) || invalid_vote) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_response", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("sb_response", {busy, vote_count, total_votes}, exp_q.pop_front());
                end
            end
            if (busy) begin
                busy_run = busy_run + 1;
                if (led == LED_ON) led_run = led_run + 1;
            end else if (busy_prev) begin
                chk("hold_len", 64'(busy_run), 64'(LH));
                chk("led_len", 64'(led_run), 64'(LH));
                chk("led_off_after_hold", led, LED_OFF);
                busy_run = 0;
                led_run  = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [CW-1:0] c1_val;

    initial begin
        model_clear();
        reset_all   = 1'b1;
        mode        = 1'b0;
        vote_logged = 1'b1;
        candidate   = 4'b0001;

        @(negedge clk);
        chk("rst_counts", vote_count, '0);
        chk("rst_total", total_votes, '0);
        chk("rst_led", led, LED_OFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_invalid", invalid_vote, 1'b0);
        chk("rst_wvalid", winner_valid, 1'b0);
        chk("rst_tie", tie, 1'b0);
        chk("rst_widx", winner_idx, '0);
        chk("rst_state", state_dbg, IDLE);

        // Strobe held high through reset release must not count.
        step();
        reset_all = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("held_counts", vote_count, '0);
        chk("held_led", led, LED_OFF);
        chk("held_invalid", invalid_vote, 1'b0);

        vote(4'b0001, LH + 2);
        @(negedge clk);
        chk("c0_count", vote_count, 32'h0000_0001);
        chk("c0_total", total_votes, 10'd1);

        // Zero-hot and multi-hot strobes are rejected.
        vote(4'b0000, LH + 2);
        vote(4'b0110, LH + 2);
        @(negedge clk);
        chk("inv_counts", vote_count, 32'h0000_0001);
        chk("inv_total", total_votes, 10'd1);
        chk("inv_led", led, LED_OFF);
        chk("inv_busy", busy, 1'b0);

        // Second strobe inside HOLD, then a level held past the end of HOLD.
        do_reset();
        vote_logged = 1'b0;
        step();
        model_vote(4'b0100);
        candidate   = 4'b0100;
        vote_logged = 1'b1;
        step();
        vote_logged = 1'b0;
        step();
        vote_logged = 1'b1;
        repeat (LH + 3) step();
        vote_logged = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("hold_ign_counts", vote_count, 32'h0001_0000);
        chk("hold_ign_total", total_votes, 10'd1);

        // Saturation of candidate 1.
        do_reset();
        repeat (255) vote(4'b0010, LH + 1);
        @(negedge clk);
        c1_val = vote_count[15:8];
        chk("sat_preload", c1_val, 8'd255);
        vote(4'b0010, LH + 2);
        @(negedge clk);
        c1_val = vote_count[15:8];
        chk("sat_count", c1_val, 8'd255);
        chk("sat_total", total_votes, 10'd255);

        // Winner and tie reporting.
        do_reset();
        repeat (3) vote(4'b0001, LH + 1);
        repeat (3) vote(4'b1000, LH + 1);
        vote(4'b0010, LH + 1);
        mode = 1'b1;
        @(negedge clk);
        chk("win_latency", winner_valid, 1'b0);
        step();
        @(negedge clk);
        chk("win1_valid", winner_valid, 1'b1);
        chk("win1_idx", winner_idx, 2'd0);
        chk("win1_tie", tie, 1'b1);
        vote(4'b0100, LH + 1);
        @(negedge clk);
        chk("mode1_ignored_total", total_votes, 10'd7);
        chk("mode1_no_invalid", invalid_vote, 1'b0);
        mode = 1'b0;
        step();
        @(negedge clk);
        chk("mode0_valid", winner_valid, 1'b0);
        chk("mode0_tie", tie, 1'b0);
        chk("mode0_idx_held", winner_idx, 2'd0);
        vote(4'b1000, LH + 1);
        mode = 1'b1;
        step();
        @(negedge clk);
        chk("win2_valid", winner_valid, 1'b1);
        chk("win2_idx", winner_idx, 2'd3);
        chk("win2_tie", tie, 1'b0);
        mode = 1'b0;
        step();

        // Asynchronous reset in the middle of HOLD.
        vote_logged = 1'b0;
        step();
        model_vote(4'b0100);
        candidate   = 4'b0100;
        vote_logged = 1'b1;
        step();
        vote_logged = 1'b0;
        @(negedge clk);
        #2;
        reset_all = 1'b1;
        #1;
        chk("arst_led", led, LED_OFF);
        chk("arst_busy", busy, 1'b0);
        chk("arst_counts", vote_count, '0);
        chk("arst_total", total_votes, '0);
        model_clear();
        @(negedge clk);
        step();
        reset_all = 1'b0;
        mode      = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("arst_wvalid", winner_valid, 1'b0);
        mode = 1'b0;
        step();

        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
